// File: rtl/pixel_row_scanner.sv
`default_nettype none
// ============================================================================
// Module   : pixel_row_scanner
// Purpose  : Scans one row of ROWS pixels. For each pixel it:
//              1. drives the mux select and waits SETTLE cycles,
//              2. requests a SAR conversion and waits for adc_done,
//                 giving up after TIMEOUT cycles,
//              3. presents the code on a valid/ready output.
//            After the last pixel has been accepted it pulses frame_done.
//            An ADC timeout substitutes an all-ones code and raises a sticky
//            error flag, which is cleared by the next start or by reset.
// Ports    : clk            - clock, rising edge
//            reset          - synchronous active-high reset
//            start          - frame request, sampled only while idle
//            decoder_select - pixel index driven to the analog mux
//            adc_enable     - conversion request to the ADC
//            adc_data       - ADC result, valid with adc_done
//            adc_done       - ADC conversion complete
//            out_data       - captured pixel code
//            out_index      - pixel index of out_data
//            out_valid      - out_data/out_index valid
//            out_ready      - downstream accepts the current beat
//            busy           - high whenever a frame is in progress
//            frame_done     - one-cycle pulse after the last beat is accepted
//            timeout_err    - sticky ADC timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module pixel_row_scanner #(
    parameter int ROWS       = 4,
    parameter int WIDTH      = 2,
    parameter int RESOLUTION = 8,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [WIDTH-1:0]      decoder_select,
    output logic                  adc_enable,
    input  logic [RESOLUTION-1:0] adc_data,
    input  logic                  adc_done,
    output logic [RESOLUTION-1:0] out_data,
    output logic [WIDTH-1:0]      out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err
);

    // One counter serves both the settle phase (up to 255) and the
    // conversion watchdog (up to 1023).
    localparam int                 c_CNT_W      = 10;
    localparam logic [c_CNT_W-1:0] c_SETTLE_END = c_CNT_W'(SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_END    = c_CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]   c_LAST_IDX   = WIDTH'(ROWS - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SETTLE  = 3'd1;
    localparam logic [2:0] c_CONVERT = 3'd2;
    localparam logic [2:0] c_HOLD    = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_index;
    logic [RESOLUTION-1:0] r_out_data;
    logic [WIDTH-1:0]      r_out_index;
    logic                  r_out_valid;
    logic                  r_timeout_err;

    logic w_frame_start;
    logic w_capture;
    logic w_timeout;
    logic w_accept;
    logic w_last;

    assign w_last = (r_index == c_LAST_IDX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = c_SETTLE;
                end
            end
            c_SETTLE: begin
                if (r_cnt == c_SETTLE_END) begin
                    w_state_nxt = c_CONVERT;
                end
            end
            c_CONVERT: begin
                // A done arriving on the watchdog's final cycle still wins,
                // so the real code is kept and no error is flagged.
                if (adc_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_HOLD;
                end else if (r_cnt == c_TMO_END) begin
                    w_capture   = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_last ? c_DONE : c_SETTLE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_index       <= '0;
            r_out_data    <= '0;
            r_out_index   <= '0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // Phase counter restarts on every state change and only runs
            // in the two timed phases.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == c_SETTLE || r_state == c_CONVERT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_frame_start) begin
                r_index       <= '0;
                r_timeout_err <= 1'b0;
            end

            if (w_capture) begin
                r_out_data  <= w_timeout ? {RESOLUTION{1'b1}} : adc_data;
                r_out_index <= r_index;
                r_out_valid <= 1'b1;
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
            end

            if (w_accept) begin
                r_out_valid <= 1'b0;
                // The index parks on the last pixel rather than wrapping.
                if (!w_last) begin
                    r_index <= r_index + WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign decoder_select = r_index;
    assign adc_enable     = (r_state == c_CONVERT);
    assign busy           = (r_state != c_IDLE);
    assign frame_done     = (r_state == c_DONE);
    assign out_data       = r_out_data;
    assign out_index      = r_out_index;
    assign out_valid      = r_out_valid;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_row_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_row_scanner
// Purpose  : Self-checking bench for pixel_row_scanner. A table of frame
//            scenarios (per-pixel ADC codes, response delays, downstream
//            stalls, expected error flag) is played through an ADC and sink
//            model; expected beats are queued when each conversion starts
//            and compared when the DUT hands them over. A hand-written
//            sequence covers reset in the middle of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_row_scanner;

    localparam int ROWS    = 4;
    localparam int WIDTH   = 2;
    localparam int RES     = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] decoder_select;
    logic             adc_enable;
    logic [RES-1:0]   adc_data;
    logic             adc_done;
    logic [RES-1:0]   out_data;
    logic [WIDTH-1:0] out_index;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;

    pixel_row_scanner #(
        .ROWS       (ROWS),
        .WIDTH      (WIDTH),
        .RESOLUTION (RES),
        .SETTLE     (SETTLE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .decoder_select (decoder_select),
        .adc_enable     (adc_enable),
        .adc_data       (adc_data),
        .adc_done       (adc_done),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Per-pixel byte lanes: lane 0 is pixel 0. A delay of 8'hFF means the
    // ADC never answers for that pixel.
    typedef struct packed {
        logic [3:0][7:0] code;
        logic [3:0][7:0] dly;
        logic [3:0][7:0] stall;
        logic            err;
        logic            noise;
    } rec_t;

    typedef struct packed {
        logic [RES-1:0]   d;
        logic [WIDTH-1:0] i;
    } exp_t;

    exp_t q[$];
    rec_t tbl[6];
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic rec_t mk(input logic [31:0] codes, input logic [31:0] dlys,
                                input logic [31:0] stalls, input logic err, input logic noise);
        rec_t r;
        r.code  = codes;
        r.dly   = dlys;
        r.stall = stalls;
        r.err   = err;
        r.noise = noise;
        return r;
    endfunction

    task automatic run_frame(input int id, input rec_t r);
        int   e = 0, got = 0, row = -1, conv = 0, stall_left = 0, lat = -1, fd = 0;
        bit   in_conv = 0, seen = 0, prev_settle = 0, settle;
        exp_t x;
        q.delete();
        @(negedge clk);
        start = 1'b1; adc_done = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("f%0d busy after start", id), 32'(busy), 32'd1);
        chk($sformatf("f%0d timeout_err cleared by start", id), 32'(timeout_err), 32'd0);
        while (got < ROWS && e < 3000) begin
            start = 1'b0; adc_done = 1'b0; adc_data = 8'($urandom); out_ready = 1'b1;
            settle = busy && !adc_enable && !out_valid && !frame_done;
            if (!adc_enable) begin
                in_conv = 0;
            end else begin
                if (!in_conv) begin
                    in_conv = 1; row++; conv = 0;
                    x.d = (int'(r.dly[row]) < TIMEOUT) ? r.code[row] : 8'hFF;
                    x.i = row[WIDTH-1:0];
                    q.push_back(x);
                    chk($sformatf("f%0d row%0d decoder_select", id, row), 32'(decoder_select), 32'(row));
                end
                if (conv == int'(r.dly[row])) begin
                    adc_done = 1'b1;
                    adc_data = r.code[row];
                end
                conv++;
            end
            // Stray done and a repeated start during the first settle cycle.
            if (r.noise && settle && !prev_settle) begin
                adc_done = 1'b1;
                start    = 1'b1;
            end
            prev_settle = settle;
            if (out_valid) begin
                if (lat < 0) lat = e;
                if (!seen) begin
                    seen = 1;
                    stall_left = int'(r.stall[got]);
                end
                if (q.size() == 0) begin
                    chk($sformatf("f%0d beat without conversion", id), 32'd1, 32'd0);
                    got++;
                end else if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    chk($sformatf("f%0d stall data", id), 32'(out_data), 32'(q[0].d));
                    chk($sformatf("f%0d stall index", id), 32'(out_index), 32'(q[0].i));
                    chk($sformatf("f%0d stall adc_enable", id), 32'(adc_enable), 32'd0);
                    chk($sformatf("f%0d stall decoder_select", id), 32'(decoder_select), 32'(q[0].i));
                end else begin
                    x = q.pop_front();
                    chk($sformatf("f%0d beat%0d data", id, got), 32'(out_data), 32'(x.d));
                    chk($sformatf("f%0d beat%0d index", id, got), 32'(out_index), 32'(x.i));
                    got++;
                    seen = 0;
                end
            end
            if (frame_done) fd++;
            @(negedge clk);
            e++;
        end
        start = 1'b0; adc_done = 1'b0; out_ready = 1'b1;
        chk($sformatf("f%0d beats within budget", id), 32'(got), 32'(ROWS));
        repeat (3) begin
            if (frame_done) fd++;
            @(negedge clk);
        end
        chk($sformatf("f%0d frame_done pulses", id), 32'(fd), 32'd1);
        chk($sformatf("f%0d busy at end", id), 32'(busy), 32'd0);
        chk($sformatf("f%0d timeout_err at end", id), 32'(timeout_err), 32'(r.err));
        chk($sformatf("f%0d leftover expected beats", id), 32'(q.size()), 32'd0);
        if (int'(r.dly[0]) < TIMEOUT)
            chk($sformatf("f%0d first beat latency", id), 32'(lat), 32'(SETTLE + 1 + int'(r.dly[0])));
    endtask

    initial begin
        int n;
        tbl[0] = mk(32'h44332211, 32'h03030303, 32'h00000000, 1'b0, 1'b0);
        tbl[1] = mk(32'h44332211, 32'h03030303, 32'h00000A00, 1'b0, 1'b0);
        tbl[2] = mk(32'h44332211, 32'h03FF0303, 32'h00000000, 1'b1, 1'b0);
        tbl[3] = mk(32'h44335A11, 32'h03033F03, 32'h00000000, 1'b0, 1'b0);
        tbl[4] = mk(32'h3CA5FF00, 32'h02050100, 32'h00030001, 1'b0, 1'b0);
        tbl[5] = mk(32'h12345678, 32'h01020304, 32'h00000000, 1'b0, 1'b1);

        reset = 1'b1; start = 1'b0; adc_done = 1'b0; adc_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset adc_enable", 32'(adc_enable), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        reset = 1'b0;

        for (int t = 0; t < 6; t++) run_frame(t, tbl[t]);

        // Reset during the conversion of pixel 1, with start/done/ready high.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(adc_enable && decoder_select == 2'd1) && n < 200) begin
            adc_done = adc_enable; adc_data = 8'h77; out_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("reached convert of pixel 1", 32'(n < 200), 32'd1);
        reset = 1'b1; start = 1'b1; adc_done = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("midframe reset decoder_select", 32'(decoder_select), 32'd0);
        chk("midframe reset adc_enable", 32'(adc_enable), 32'd0);
        chk("midframe reset out_data", 32'(out_data), 32'd0);
        chk("midframe reset out_index", 32'(out_index), 32'd0);
        chk("midframe reset out_valid", 32'(out_valid), 32'd0);
        chk("midframe reset busy", 32'(busy), 32'd0);
        chk("midframe reset frame_done", 32'(frame_done), 32'd0);
        chk("midframe reset timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0; start = 1'b0; adc_done = 1'b0;
        @(negedge clk);
        run_frame(6, tbl[0]);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
